de_pipe_reg: RTL and testbench
==============================

Name: de_pipe_reg

Overview:
- D/E pipeline register of the P5 five-stage MIPS core.
- Captures the decode-stage bundle each cycle and presents it to the execute stage:
  - PC and instruction
  - forwarded GPR read data
  - the immediate already extended by the decode-stage immediate extender
  - destination register and Tnew
- Turns a hazard-unit stall into a bubble (nop) in E.
- Pre-ages Tnew so the hazard unit can compare E-stage Tnew directly against Tuse.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into E_PC on reset (text segment base).
- TNEW_W, 2, width of the Tnew fields.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- stall  in  1  from the hazard unit; 1 = insert a bubble into E this cycle.
- D_PC  in  32  PC of the instruction in D.
- D_Instr  in  32  instruction word in D.
- D_RD1  in  32  rs value after D-stage forwarding.
- D_RD2  in  32  rt value after D-stage forwarding.
- D_EXTOut  in  32  extended immediate (zero / sign / lui / ones-high form, already applied).
- D_A3  in  5  destination GPR index (0 = no write).
- D_Tnew  in  TNEW_W  cycles, counted from D, until the result is produced.
- E_PC  out  32  registered PC.
- E_Instr  out  32  registered instruction; 32'h0 = nop.
- E_RD1  out  32  registered rs value.
- E_RD2  out  32  registered rt value.
- E_EXTOut  out  32  registered extended immediate.
- E_A3  out  5  registered destination GPR.
- E_Tnew  out  TNEW_W  Tnew as seen in E.
- E_valid  out  1  1 = E holds a real instruction; 0 = reset state or bubble.

Behaviour:
- All outputs are driven directly from flops. There is no combinational path from any input to any output.
- Update priority on each rising clk edge: reset > stall > load.
- Reset:
  - E_PC = PC_RESET.
  - E_Instr, E_RD1, E_RD2, E_EXTOut = 0.
  - E_A3 = 0, E_Tnew = 0, E_valid = 0.
- Stall (reset = 0, stall = 1), bubble:
  - E_Instr, E_RD1, E_RD2, E_EXTOut = 0.
  - E_A3 = 0, E_Tnew = 0, E_valid = 0.
  - E_PC = D_PC. PC is retained for later exception/EPC use; it does not revert to PC_RESET.
- Load (reset = 0, stall = 0):
  - E_PC, E_Instr, E_RD1, E_RD2, E_EXTOut take the corresponding D_* values.
  - E_valid = 1.
  - E_Tnew = D_Tnew − 1, saturating at 0 (D_Tnew = 0 gives 0; D_Tnew = 3 gives 2).
  - $0 suppression: if D_A3 == 0, then E_A3 = 0 and E_Tnew = 0 regardless of D_Tnew, so writes to $0 are never forwarded. Otherwise E_A3 = D_A3.
- Latency: exactly one cycle from D_* to E_*. Back-to-back loads are allowed every cycle.
- The block holds no other state:
  - A stall lasting N cycles produces N consecutive bubbles.
  - The first edge after stall deasserts loads the current D bundle.
- Reset asserted mid-stream overrides everything in that same edge. The in-flight D bundle is discarded and is not loaded.
- reset and stall asserted together: reset wins, so E_PC = PC_RESET, not D_PC.

Test Plan:
- Reset: hold reset 2 cycles with random D_* inputs -> E_PC = 32'h3000, every other output 0, E_valid = 0.
- Plain load: D_PC = 32'h3004, D_Instr = 32'h3c011234, D_EXTOut = 32'h12340000, D_A3 = 1, D_Tnew = 2 -> next cycle E_* mirror these values, E_Tnew = 1, E_valid = 1.
- Tnew saturation and $0:
  - D_Tnew = 0, D_A3 = 5 -> E_Tnew = 0, E_A3 = 5.
  - D_Tnew = 2, D_A3 = 0 -> E_A3 = 0, E_Tnew = 0.
- Bubble: stall = 1 for 3 cycles with D_PC = 32'h3010, D_Instr = 32'h8c220004 -> 3 consecutive cycles of E_Instr = 0, E_valid = 0, E_PC = 32'h3010. The 4th edge (stall = 0) loads 32'h8c220004.
- Reset over stall: reset = 1 and stall = 1 on the same edge, D_PC = 32'h3020 -> E_PC = 32'h3000, E_valid = 0.
- Streaming: 8 back-to-back random bundles with stall = 0 -> each E bundle equals the D bundle of the previous cycle, checked against a reference model including the Tnew and $0 rules.

Source files
------------

// File: rtl/de_pipe_reg_if.sv
// de_pipe_reg_if
//   Bundle between the decode stage / hazard unit and the D/E pipeline register.
//   slave  modport : the pipeline register (reads D_* and stall, drives E_*).
//   master modport : the decode side (drives D_* and stall, observes E_*).
//   Signals:
//     stall                 1 = bubble into E on the next edge
//     D_PC, D_Instr         PC and instruction word in D
//     D_RD1, D_RD2          forwarded rs / rt values
//     D_EXTOut              extended immediate
//     D_A3, D_Tnew          destination GPR and Tnew counted from D
//     E_* (same set)        registered copies presented to E
//     E_valid               E holds a real instruction
interface de_pipe_reg_if #(
  parameter int TNEW_W = 2
);
  logic              stall;
  logic [31:0]       D_PC;
  logic [31:0]       D_Instr;
  logic [31:0]       D_RD1;
  logic [31:0]       D_RD2;
  logic [31:0]       D_EXTOut;
  logic [4:0]        D_A3;
  logic [TNEW_W-1:0] D_Tnew;
  logic [31:0]       E_PC;
  logic [31:0]       E_Instr;
  logic [31:0]       E_RD1;
  logic [31:0]       E_RD2;
  logic [31:0]       E_EXTOut;
  logic [4:0]        E_A3;
  logic [TNEW_W-1:0] E_Tnew;
  logic              E_valid;

  modport slave (
    input  stall, D_PC, D_Instr, D_RD1, D_RD2, D_EXTOut, D_A3, D_Tnew,
    output E_PC, E_Instr, E_RD1, E_RD2, E_EXTOut, E_A3, E_Tnew, E_valid
  );

  modport master (
    output stall, D_PC, D_Instr, D_RD1, D_RD2, D_EXTOut, D_A3, D_Tnew,
    input  E_PC, E_Instr, E_RD1, E_RD2, E_EXTOut, E_A3, E_Tnew, E_valid
  );
endinterface

// File: rtl/de_pipe_reg.sv
// de_pipe_reg
//   D/E pipeline register of the five-stage MIPS core. Captures the decode
//   bundle every cycle, turns a stall into a bubble (nop) in E and pre-ages
//   Tnew by one so E-stage Tnew compares directly against Tuse.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset
//     bus    slave modport of de_pipe_reg_if (stall, D_* in, E_* out)
//   All E_* outputs come straight from flops.
module de_pipe_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  de_pipe_reg_if.slave    bus
);

  localparam logic [TNEW_W-1:0] TNEW_ZERO = {TNEW_W{1'b0}};
  localparam logic [TNEW_W-1:0] TNEW_ONE  = {{(TNEW_W-1){1'b0}}, 1'b1};

  // Tnew as seen one stage later: decrement, saturating at zero.
  function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
    if (t == TNEW_ZERO) begin
      return TNEW_ZERO;
    end else begin
      return t - TNEW_ONE;
    end
  endfunction

  logic [31:0]       pc_d,    pc_q;
  logic [31:0]       instr_d, instr_q;
  logic [31:0]       rd1_d,   rd1_q;
  logic [31:0]       rd2_d,   rd2_q;
  logic [31:0]       ext_d,   ext_q;
  logic [4:0]        a3_d,    a3_q;
  logic [TNEW_W-1:0] tnew_d,  tnew_q;
  logic              valid_d, valid_q;

  // Next-state: bubble on stall, otherwise load the decode bundle.
  always_comb begin
    pc_d    = bus.D_PC;   // PC survives a bubble for later EPC use
    instr_d = 32'h0000_0000;
    rd1_d   = 32'h0000_0000;
    rd2_d   = 32'h0000_0000;
    ext_d   = 32'h0000_0000;
    a3_d    = 5'd0;
    tnew_d  = TNEW_ZERO;
    valid_d = 1'b0;
    if (bus.stall) begin
      valid_d = 1'b0;
    end else begin
      instr_d = bus.D_Instr;
      rd1_d   = bus.D_RD1;
      rd2_d   = bus.D_RD2;
      ext_d   = bus.D_EXTOut;
      valid_d = 1'b1;
      // A write to $0 is never a real producer, so it must not look forwardable.
      if (bus.D_A3 == 5'd0) begin
        a3_d   = 5'd0;
        tnew_d = TNEW_ZERO;
      end else begin
        a3_d   = bus.D_A3;
        tnew_d = tnew_age(bus.D_Tnew);
      end
    end
  end

  // State register; reset has priority over stall and load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0000_0000;
      rd1_q   <= 32'h0000_0000;
      rd2_q   <= 32'h0000_0000;
      ext_q   <= 32'h0000_0000;
      a3_q    <= 5'd0;
      tnew_q  <= TNEW_ZERO;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ext_q   <= ext_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end

  assign bus.E_PC     = pc_q;
  assign bus.E_Instr  = instr_q;
  assign bus.E_RD1    = rd1_q;
  assign bus.E_RD2    = rd2_q;
  assign bus.E_EXTOut = ext_q;
  assign bus.E_A3     = a3_q;
  assign bus.E_Tnew   = tnew_q;
  assign bus.E_valid  = valid_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg
//   Directed bench for de_pipe_reg: reset, load, Tnew/$0 rules, bubbles,
//   reset-over-stall and a short streaming run against a small model.
module tb_de_pipe_reg;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  de_pipe_reg_if #(.TNEW_W(2)) bus ();

  de_pipe_reg #(.PC_RESET(32'h0000_3000), .TNEW_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Check every E-stage output.
  task automatic check_e(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] ext,
                         input logic [4:0] a3, input logic [1:0] tnew, input logic valid);
    check_val({tag, ".pc"},    bus.E_PC,     pc);
    check_val({tag, ".instr"}, bus.E_Instr,  instr);
    check_val({tag, ".rd1"},   bus.E_RD1,    rd1);
    check_val({tag, ".rd2"},   bus.E_RD2,    rd2);
    check_val({tag, ".ext"},   bus.E_EXTOut, ext);
    check_val({tag, ".a3"},    {27'd0, bus.E_A3},   {27'd0, a3});
    check_val({tag, ".tnew"},  {30'd0, bus.E_Tnew}, {30'd0, tnew});
    check_val({tag, ".valid"}, {31'd0, bus.E_valid}, {31'd0, valid});
  endtask

  // Drive one decode bundle.
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] ext, input logic [4:0] a3,
                       input logic [1:0] tnew);
    bus.D_PC     = pc;
    bus.D_Instr  = instr;
    bus.D_RD1    = rd1;
    bus.D_RD2    = rd2;
    bus.D_EXTOut = ext;
    bus.D_A3     = a3;
    bus.D_Tnew   = tnew;
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s_pc, s_in, s_r1, s_r2, s_ex;
    logic [4:0]  s_a3;
    logic [1:0]  s_tn, e_tn;

    // Reset with random decode inputs.
    reset     = 1'b1;
    bus.stall = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)));
    step();
    check_e("rst1", 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)));
    step();
    check_e("rst2", 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);

    // Plain load (lui $1, 0x1234).
    reset = 1'b0;
    drive(32'h3004, 32'h3c011234, 32'hAAAA_5555, 32'h0BAD_F00D, 32'h1234_0000, 5'd1, 2'd2);
    step();
    check_e("load", 32'h3004, 32'h3c011234, 32'hAAAA_5555, 32'h0BAD_F00D, 32'h1234_0000, 5'd1, 2'd1, 1'b1);

    // Tnew saturation at zero.
    drive(32'h3008, 32'h0000_2821, 32'h11, 32'h22, 32'h0, 5'd5, 2'd0);
    step();
    check_e("tsat", 32'h3008, 32'h0000_2821, 32'h11, 32'h22, 32'h0, 5'd5, 2'd0, 1'b1);

    // Maximum Tnew ages to 2.
    drive(32'h300c, 32'h8c23_0000, 32'h33, 32'h44, 32'h0, 5'd3, 2'd3);
    step();
    check_e("tmax", 32'h300c, 32'h8c23_0000, 32'h33, 32'h44, 32'h0, 5'd3, 2'd2, 1'b1);

    // Write to $0 is suppressed.
    drive(32'h300c, 32'h3c00_0001, 32'h55, 32'h66, 32'h0001_0000, 5'd0, 2'd2);
    step();
    check_e("zero", 32'h300c, 32'h3c00_0001, 32'h55, 32'h66, 32'h0001_0000, 5'd0, 2'd0, 1'b1);

    // Three-cycle stall produces three bubbles, then the held bundle loads.
    drive(32'h3010, 32'h8c220004, 32'h77, 32'h88, 32'h4, 5'd2, 2'd3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_e($sformatf("bub%0d", i), 32'h3010, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    check_e("unstall", 32'h3010, 32'h8c220004, 32'h77, 32'h88, 32'h4, 5'd2, 2'd2, 1'b1);

    // Reset and stall on the same edge: reset wins.
    reset     = 1'b1;
    bus.stall = 1'b1;
    drive(32'h3020, 32'h1234_5678, 32'h99, 32'haa, 32'hbb, 5'd7, 2'd2);
    step();
    check_e("rststall", 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    // Back-to-back random bundles against the reference rules.
    for (int i = 0; i < 8; i++) begin
      s_pc = 32'h3100 + 32'(i * 4);
      s_in = $urandom;
      s_r1 = $urandom;
      s_r2 = $urandom;
      s_ex = $urandom;
      s_a3 = (i % 3 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s_tn = 2'(i % 4);
      if (s_a3 == 5'd0)      e_tn = 2'd0;
      else if (s_tn == 2'd0) e_tn = 2'd0;
      else                   e_tn = s_tn - 2'd1;
      drive(s_pc, s_in, s_r1, s_r2, s_ex, s_a3, s_tn);
      step();
      check_e($sformatf("strm%0d", i), s_pc, s_in, s_r1, s_r2, s_ex, s_a3, e_tn, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
